// File: rtl/stream_packer.sv
// Narrow-to-wide stream packer: gathers RATIO words of ELEM_WIDTH bits into one
// wide word with per-lane keep bits. A packet may end early via data_in_last.

module stream_packer_lane #(
  parameter int W   = 32,
  parameter int IDX = 0,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          in_xfer,
  input  logic          complete,
  input  logic [CW-1:0] cnt,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  merged_data,
  output logic          merged_keep
);
  logic [W-1:0] data_q;
  logic         keep_q;
  logic         sel;

  assign sel = (cnt == CW'(IDX));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_q <= '0;
      keep_q <= 1'b0;
    end else if (complete) begin
      data_q <= '0;
      keep_q <= 1'b0;
    end else if (in_xfer && sel) begin
      data_q <= din;
      keep_q <= 1'b1;
    end
  end

  // Lanes above cnt are still cleared, so a partial word carries zeros there.
  assign merged_data = sel ? din : data_q;
  assign merged_keep = keep_q | sel;
endmodule

module stream_packer #(
  parameter int ELEM_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [ELEM_WIDTH-1:0]       data_in,
  input  logic                        data_in_val,
  input  logic                        data_in_last,
  output logic                        data_in_rdy,
  output logic [ELEM_WIDTH*RATIO-1:0] data_out,
  output logic [RATIO-1:0]            data_out_keep,
  output logic                        data_out_last,
  output logic                        data_out_val,
  input  logic                        data_out_rdy
);
  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]                       cnt;
  logic                                in_xfer;
  logic                                complete;
  logic [RATIO-1:0][ELEM_WIDTH-1:0]    mrg_data;
  logic [RATIO-1:0]                    mrg_keep;

  assign data_in_rdy = !data_out_val || data_out_rdy;
  assign in_xfer     = data_in_val && data_in_rdy;
  assign complete    = in_xfer && ((cnt == CW'(RATIO-1)) || data_in_last);

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    stream_packer_lane #(
      .W   (ELEM_WIDTH),
      .IDX (g),
      .CW  (CW)
    ) u_lane (
      .clk         (clk),
      .arst        (arst),
      .in_xfer     (in_xfer),
      .complete    (complete),
      .cnt         (cnt),
      .din         (data_in),
      .merged_data (mrg_data[g]),
      .merged_keep (mrg_keep[g])
    );
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (complete) begin
      cnt <= '0;
    end else if (in_xfer) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output register reloads on completion even while draining, giving full rate.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_out      <= '0;
      data_out_keep <= '0;
      data_out_last <= 1'b0;
      data_out_val  <= 1'b0;
    end else if (complete) begin
      data_out      <= mrg_data;
      data_out_keep <= mrg_keep;
      data_out_last <= data_in_last;
      data_out_val  <= 1'b1;
    end else if (data_out_val && data_out_rdy) begin
      data_out_val  <= 1'b0;
    end
  end
endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter ELEM_WIDTH, default 32, SHALL set the narrow input word width in bits.
REQ-002 Parameter RATIO, default 4, SHALL set the number of input words per output word; legal range 2..16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 arst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 data_in  input  ELEM_WIDTH  SHALL carry the narrow input word.
REQ-006 data_in_val  input  1  SHALL qualify data_in and data_in_last.
REQ-007 data_in_last  input  1  SHALL mark the final word of a packet.
REQ-008 data_in_rdy  output  1  SHALL indicate that the block accepts the input word this cycle.
REQ-009 data_out  output  ELEM_WIDTH*RATIO  SHALL carry the packed wide word.
REQ-010 data_out_keep  output  RATIO  SHALL carry one bit per lane; 1 = lane holds valid data.
REQ-011 data_out_last  output  1  SHALL mark the final wide word of a packet.
REQ-012 data_out_val  output  1  SHALL qualify data_out, data_out_keep and data_out_last.
REQ-013 data_out_rdy  input  1  SHALL indicate downstream acceptance, typically a pipeline_full data_in_rdy.

Function
REQ-014 An input transfer SHALL occur when data_in_val && data_in_rdy; an output transfer SHALL occur when data_out_val && data_out_rdy.
REQ-015 data_in_rdy SHALL equal !data_out_val || data_out_rdy; this is the only combinational in-to-out path and it is permitted.
REQ-016 Lane counter cnt (0..RATIO-1) SHALL select the destination lane; lane k occupies data bits [k*ELEM_WIDTH +: ELEM_WIDTH].
REQ-017 On an input transfer that is not completing, the word SHALL be written into assembly lane cnt, its assembly keep bit set, and cnt incremented.
REQ-018 An input transfer SHALL be completing when cnt == RATIO-1 or data_in_last == 1.
REQ-019 On a completing input transfer, the next-cycle output register SHALL be loaded with the assembly content merged with the current word at lane cnt; keep bits 0..cnt set; last = data_in_last; data_out_val = 1.
REQ-019a On a completing transfer, cnt SHALL return to 0 and the assembly data and keep SHALL clear to 0.
REQ-020 Lanes above cnt in a partial (last-terminated) word SHALL be driven 0 with keep bits 0.
REQ-021 Latency SHALL be one cycle from the completing input transfer to data_out_val high.
REQ-022 Sustained throughput SHALL be one input word per cycle while data_out_rdy is held 1.
REQ-023 While data_out_val && !data_out_rdy, the output register SHALL hold data_out, keep, last and val stable, and no input SHALL be accepted.
REQ-024 On an output transfer with no simultaneous completing input transfer, data_out_val SHALL go 0 next cycle.
REQ-024a On an output transfer with a simultaneous completing input transfer, data_out_val SHALL stay 1 and the register SHALL be reloaded with the new word.
REQ-025 data_in_last with cnt == RATIO-1 SHALL produce a full-keep word with data_out_last = 1.
REQ-025a data_in_last with cnt == 0 SHALL produce keep = 1 (lane 0 only).
REQ-026 data_in SHALL be ignored when data_in_val == 0 or data_in_rdy == 0; cnt SHALL then hold.

Reset
REQ-027 While arst == 1, the block SHALL asynchronously force data_out = 0, data_out_keep = 0, data_out_last = 0, data_out_val = 0, cnt = 0, and assembly data and keep = 0.
REQ-028 After reset, data_in_rdy SHALL be 1; reset mid-packet SHALL discard any partially assembled word, and no output SHALL be produced for it.
REQ-029 The first input after reset deassertion SHALL land in lane 0.

Verification (ELEM_WIDTH=8, RATIO=4)
REQ-030 Full word: inputs 0x11,0x22,0x33,0x44 on consecutive cycles, last=0, out_rdy=1 -> one cycle after the 4th input, data_out=0x44332211, keep=0xF, last=0, val=1 for one cycle.
REQ-031 Partial word: inputs 0xA1,0xA2 with last=1 on 0xA2 -> data_out=0x0000A2A1, keep=0x3, last=1.
REQ-032 Backpressure: complete word 0x44332211, hold out_rdy=0 for 5 cycles -> in_rdy=0, output stable; on out_rdy=1, next word 0x88776655 streams without loss or reordering.
REQ-033 Back-to-back: 8 inputs 0x01..0x08 with out_rdy=1 -> 0x04030201 then 0x08070605 on consecutive output-valid windows, with no input-side bubbles.
REQ-034 Single-word packet: one input 0x5A with last=1 at cnt=0 -> data_out=0x0000005A, keep=0x1, last=1.
REQ-035 Reset mid-packet: inputs 0x11,0x22, assert arst for 1 cycle, then inputs 0x33,0x44,0x55,0x66 -> all outputs 0 during reset, then data_out=0x66554433, keep=0xF.
